// File: rtl/psum_gather_if.sv
// Handshake and data bundle for the four-lane partial-sum gatherer.
// The master side issues bursts and terms; the slave side is the gatherer.
interface psum_gather_if #(
  parameter int LEN_W = 5
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_d0;
  logic [7:0]       in_d1;
  logic [7:0]       in_d2;
  logic [7:0]       in_d3;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      psum0;
  logic [11:0]      psum1;
  logic [11:0]      psum2;
  logic [11:0]      psum3;

  modport master (
    output start, len, in_valid, in_d0, in_d1, in_d2, in_d3, out_ready,
    input  busy, in_ready, out_valid, psum0, psum1, psum2, psum3
  );

  modport slave (
    input  start, len, in_valid, in_d0, in_d1, in_d2, in_d3, out_ready,
    output busy, in_ready, out_valid, psum0, psum1, psum2, psum3
  );
endinterface

// File: rtl/psum_gather.sv
// Four-lane partial-sum gatherer: after a start with a nonzero length it
// accumulates that many term sets into per-lane 12-bit wrapping sums, then
// holds the result until the downstream reducer takes it.
module psum_gather #(
  parameter int LEN_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  psum_gather_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [11:0]      psum_q [4];
  logic [11:0]      psum_d [4];
  logic [7:0]       term   [4];

  assign term[0] = bus.in_d0;
  assign term[1] = bus.in_d1;
  assign term[2] = bus.in_d2;
  assign term[3] = bus.in_d3;

  // Next-state, count and sum update for the three-state burst controller.
  always_comb begin
    // NOTE: every target gets a hold-value default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    psum_d  = psum_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          for (int k = 0; k < 4; k++) psum_d[k] = '0;
          count_d = bus.len;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          for (int k = 0; k < 4; k++) psum_d[k] = psum_q[k] + {4'd0, term[k]};
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, count and sum registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      // NOTE: the sums are a handful of flops, not a memory, so they are reset so a cleared result is visible at once.
      for (int k = 0; k < 4; k++) psum_q[k] <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q <= state_d;
      count_q <= count_d;
      psum_q  <= psum_d;
    end
  end

  // Status flags are pure decodes of the registered state.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q == ACCUM) || (state_q == HOLD);

  assign bus.psum0 = psum_q[0];
  assign bus.psum1 = psum_q[1];
  assign bus.psum2 = psum_q[2];
  assign bus.psum3 = psum_q[3];

endmodule

// File: tb/tb_psum_gather.sv
// Randomized and directed bench for psum_gather against a sum-of-terms model.
module tb_psum_gather;

  localparam int LEN_W = 5;

  logic clk;
  logic rst;

  psum_gather_if #(.LEN_W(LEN_W)) bus ();

  psum_gather #(.LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Term sets for the next burst, and expected per-lane totals (unbounded ints).
  int terms   [32][4];
  int exp_sum [4];
  // Stall mode: 0 none, 1 random, 2 exactly three idle cycles after transfer 1.
  int stall_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] psum_of(input int k);
    case (k)
      0: return bus.psum0;
      1: return bus.psum1;
      2: return bus.psum2;
      default: return bus.psum3;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sums(input string tag);
    for (int k = 0; k < 4; k++) check(tag, 32'(psum_of(k)), 32'(exp_sum[k] % 4096));
  endtask

  task automatic drive_terms(input int idx);
    bus.in_d0 = 8'(terms[idx][0]);
    bus.in_d1 = 8'(terms[idx][1]);
    bus.in_d2 = 8'(terms[idx][2]);
    bus.in_d3 = 8'(terms[idx][3]);
  endtask

  // Full burst: start, n transfers (with stalls), bp cycles of backpressure, handshake.
  task automatic do_burst(input int n, input int bp);
    int done;
    int stalls;
    int cycles;
    bit v;
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    step();
    for (int k = 0; k < 4; k++) exp_sum[k] = 0;
    check("start_busy", 32'(bus.busy), 1);
    check("start_in_ready", 32'(bus.in_ready), 1);
    check_sums("start_cleared");
    done = 0;
    stalls = 0;
    cycles = 0;
    while (done < n && cycles < 200) begin
      cycles++;
      case (stall_mode)
        1:       v = 1'($urandom_range(0, 1));
        2:       v = (done != 1) || (stalls >= 3);
        default: v = 1'b1;
      endcase
      if (!v) stalls++;
      bus.in_valid = v;
      drive_terms(done);
      // Start with a fresh length during ACCUM must not reload the count.
      bus.start = 1'($urandom_range(0, 1));
      bus.len   = LEN_W'($urandom_range(1, 31));
      step();
      if (v) begin
        for (int k = 0; k < 4; k++) exp_sum[k] += terms[done][k];
        done++;
      end
      check_sums("accum_sum");
      if (done < n) begin
        check("accum_in_ready", 32'(bus.in_ready), 1);
        check("accum_out_valid", 32'(bus.out_valid), 0);
      end else begin
        check("hold_out_valid", 32'(bus.out_valid), 1);
        check("hold_in_ready", 32'(bus.in_ready), 0);
      end
    end
    check("accum_budget", 32'(done), 32'(n));
    bus.in_valid = 1'b0;
    for (int i = 0; i < bp; i++) begin
      bus.out_ready = 1'b0;
      bus.start     = 1'b1;
      bus.len       = LEN_W'($urandom_range(1, 31));
      step();
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_busy", 32'(bus.busy), 1);
      check_sums("bp_stable");
    end
    // Handshake edge, with a start that must be ignored.
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.len       = LEN_W'(3);
    step();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("ack_out_valid", 32'(bus.out_valid), 0);
    check("ack_busy", 32'(bus.busy), 0);
    check_sums("ack_retained");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    stall_mode = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_d0 = '0;
    bus.in_d1 = '0;
    bus.in_d2 = '0;
    bus.in_d3 = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) exp_sum[k] = 0;

    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check_sums("rst_sums");
    #11;
    rst = 1'b1;

    // Basic burst, started on the first edge after release.
    terms[0] = '{1, 2, 3, 4};
    terms[1] = '{10, 20, 30, 40};
    terms[2] = '{100, 100, 100, 100};
    do_burst(3, 0);
    check("basic_lane3", 32'(bus.psum3), 144);

    // len=0 start in IDLE is ignored; previous result stays.
    bus.start = 1'b1;
    bus.len   = '0;
    step();
    bus.start = 1'b0;
    check("len0_busy", 32'(bus.busy), 0);
    check_sums("len0_sums");

    // Wrap: 17 x 255 on every lane.
    for (int i = 0; i < 17; i++) terms[i] = '{255, 255, 255, 255};
    do_burst(17, 1);
    check("wrap_lane0", 32'(bus.psum0), 239);

    // Stalls between two terms 5 and 7.
    stall_mode = 2;
    terms[0] = '{5, 5, 5, 5};
    terms[1] = '{7, 7, 7, 7};
    do_burst(2, 4);
    check("stall_lane1", 32'(bus.psum1), 12);

    // Reset mid-burst after 2 of 5 transfers, asserted between edges.
    stall_mode = 0;
    bus.start = 1'b1;
    bus.len   = LEN_W'(5);
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    terms[0] = '{50, 60, 70, 80};
    drive_terms(0);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) exp_sum[k] = 0;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check_sums("mid_rst_sums");
    #3;
    rst = 1'b1;
    check("post_rst_out_valid", 32'(bus.out_valid), 0);
    terms[0] = '{9, 9, 9, 9};
    do_burst(1, 0);
    check("post_rst_lane2", 32'(bus.psum2), 9);

    // Random bursts with random stalls and backpressure.
    stall_mode = 1;
    for (int b = 0; b < 20; b++) begin
      int n;
      n = $urandom_range(1, 31);
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) terms[i][k] = $urandom_range(0, 255);
      do_burst(n, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
